// File: rtl/sdram_wb_pkg.sv
// Shared FSM type, default widths and counter width for the SDRAM Wishbone master.
package sdram_wb_pkg;

    localparam int DEF_ADDR_W  = 24;
    localparam int DEF_DATA_W  = 16;
    localparam int ERR_COUNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/sdram_wb_watchdog.sv
// Bus-cycle watchdog: counts enabled cycles and flags the last allowed one.
module sdram_wb_watchdog #(
    parameter int LIMIT = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q holds the number of earlier enabled cycles, so expire marks the LIMIT-th one.
    assign expire = enable && (cnt_q == CNT_W'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sdram_wb_master.sv
// Single-outstanding Wishbone classic initiator for the SDRAM controller user port.
// Optional bus-cycle timeout is enabled by defining SDRAM_WB_MASTER_TIMEOUT_EN.
module sdram_wb_master
    import sdram_wb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   init_done,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_we,
    input  logic [ADDR_W-1:0]      cmd_adr,
    input  logic [DATA_W-1:0]      cmd_dat,
    input  logic [DATA_W/8-1:0]    cmd_sel,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_dat,
    output logic                   rsp_err,
    output logic                   rsp_we,
    output logic [ADDR_W-1:0]      wb_adr,
    output logic [DATA_W-1:0]      wb_dat_w,
    input  logic [DATA_W-1:0]      wb_dat_r,
    output logic [DATA_W/8-1:0]    wb_sel,
    output logic                   wb_cyc,
    output logic                   wb_stb,
    output logic                   wb_we,
    input  logic                   wb_ack,
    input  logic                   wb_err,
    output logic [ERR_COUNT_W-1:0] err_count,
    output state_t                 state_dbg
);

    localparam int SEL_W = DATA_W / 8;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      adr_q, adr_d;
    logic [DATA_W-1:0]      dat_w_q, dat_w_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic                   we_q, we_d;
    logic [DATA_W-1:0]      rsp_dat_q, rsp_dat_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [ERR_COUNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                   in_bus;
    logic                   timeout;
    logic                   term_err;

    assign in_bus = (state_q == BUS);

`ifdef SDRAM_WB_MASTER_TIMEOUT_EN
    sdram_wb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!in_bus),
        .enable (in_bus),
        .expire (timeout)
    );
`else
    assign timeout = 1'b0;
    // TIMEOUT_CYCLES has no effect in this build; a bus cycle waits indefinitely.
    if (TIMEOUT_CYCLES < 1) begin : g_no_timeout
    end
`endif

    // Handshakes: a transfer happens on any edge where valid and ready are both 1;
    // the producer holds valid and payload stable until that edge.
    assign cmd_ready = rst_n && init_done && (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);

    assign wb_cyc    = in_bus;
    assign wb_stb    = in_bus;
    assign wb_we     = in_bus && we_q;
    assign wb_adr    = adr_q;
    assign wb_dat_w  = dat_w_q;
    assign wb_sel    = sel_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_we    = we_q;
    assign err_count = err_cnt_q;
    assign state_dbg = state_q;

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_w_d   = dat_w_q;
        sel_d     = sel_q;
        we_d      = we_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        err_cnt_d = err_cnt_q;
        term_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    adr_d   = cmd_adr;
                    dat_w_d = cmd_dat;
                    sel_d   = cmd_sel;
                    we_d    = cmd_we;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wb_ack || wb_err || timeout) begin
                    // A real ack beats a simultaneous timeout; err always wins.
                    term_err  = wb_err || (timeout && !wb_ack);
                    rsp_err_d = term_err;
                    rsp_dat_d = (term_err || we_q) ? '0 : wb_dat_r;
                    if (term_err && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            adr_q     <= '0;
            dat_w_q   <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_w_q   <= dat_w_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_sdram_wb_master.sv
// Directed and randomized bench for sdram_wb_master with a Wishbone memory responder.
module tb_sdram_wb_master;
    import sdram_wb_pkg::*;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_done = 1'b0;
    always #5 clk = ~clk;

    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_we = 1'b0;
    logic [AW-1:0]   cmd_adr = '0;
    logic [DW-1:0]   cmd_dat = '0;
    logic [SW-1:0]   cmd_sel = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [DW-1:0]   rsp_dat;
    logic            rsp_err;
    logic            rsp_we;
    logic [AW-1:0]   wb_adr;
    logic [DW-1:0]   wb_dat_w;
    logic [DW-1:0]   wb_dat_r;
    logic [SW-1:0]   wb_sel;
    logic            wb_cyc;
    logic            wb_stb;
    logic            wb_we;
    logic            wb_ack;
    logic            wb_err;
    logic [15:0]     err_count;
    state_t          state_dbg;

    sdram_wb_master #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_done (init_done),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .rsp_we    (rsp_we),
        .wb_adr    (wb_adr),
        .wb_dat_w  (wb_dat_w),
        .wb_dat_r  (wb_dat_r),
        .wb_sel    (wb_sel),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_we     (wb_we),
        .wb_ack    (wb_ack),
        .wb_err    (wb_err),
        .err_count (err_count),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    logic [DW+1:0] exp_q[$];          // {we, err, data}
    logic [15:0]   exp_errs = '0;
    logic [DW-1:0] slv_mem[4096];
    logic [DW-1:0] ref_mem[4096];

    // Responder controls: 0 ack, 1 err, 2 ack+err, 3 silent.
    int   resp_delay = 0;
    int   resp_mode  = 0;
    logic stray      = 1'b0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                            input logic [SW-1:0] sel);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < SW; b++) begin
            if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- Wishbone memory responder ----------------
    initial begin : responder
        int bus_cnt;
        bit hit;
        bus_cnt  = 0;
        wb_ack   = 1'b0;
        wb_err   = 1'b0;
        wb_dat_r = '0;
        forever begin
            @(negedge clk);
            hit = 1'b0;
            if (wb_cyc && wb_stb) begin
                hit = (resp_mode != 3) && (bus_cnt == resp_delay);
                bus_cnt++;
            end else begin
                bus_cnt = 0;
            end
            wb_ack   = (hit && (resp_mode != 1)) || stray;
            wb_err   = (hit && (resp_mode != 0)) || stray;
            wb_dat_r = (hit && !wb_we) ? slv_mem[wb_adr[11:0]] : DW'($urandom);
            if (hit && wb_we && (resp_mode == 0)) begin
                slv_mem[wb_adr[11:0]] = merge(slv_mem[wb_adr[11:0]], wb_dat_w, wb_sel);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                            input logic [SW-1:0] sel, input string tag);
        int w;
        w = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_accept"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_we    = 1'($urandom);
        cmd_adr   = AW'($urandom);
        cmd_dat   = DW'($urandom);
    endtask

    task automatic run_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                           input logic [SW-1:0] sel, input int delay, input int mode,
                           input int bp, input bit drop_init, input string tag);
        logic [DW+1:0] exp;
        logic [DW-1:0] hold_dat;
        int k, cyc_cnt, exp_cyc;
        bit seen;
        // Reference model: one response per command, error responses carry zero data.
        if (mode != 0) begin
            if (exp_errs != 16'hFFFF) exp_errs++;
            exp_q.push_back({we, 1'b1, {DW{1'b0}}});
        end else if (we) begin
            ref_mem[adr[11:0]] = merge(ref_mem[adr[11:0]], dat, sel);
            exp_q.push_back({1'b1, 1'b0, {DW{1'b0}}});
        end else begin
            exp_q.push_back({1'b0, 1'b0, ref_mem[adr[11:0]]});
        end
        exp_cyc    = (mode == 3) ? TO : delay + 1;
        resp_delay = delay;
        resp_mode  = mode;
        send_cmd(we, adr, dat, sel, tag);
        k = 0;
        cyc_cnt = 0;
        seen = 1'b0;
        while (k < 40 && !seen) begin
            @(negedge clk);
            k++;
            if (wb_cyc) begin
                if (cyc_cnt == 0) begin
                    chk({tag, "_wb_adr"}, 32'(wb_adr), 32'(adr));
                    chk({tag, "_wb_we"}, 32'(wb_we), 32'(we));
                    chk({tag, "_wb_sel"}, 32'(wb_sel), 32'(sel));
                    chk({tag, "_wb_stb"}, 32'(wb_stb), 32'd1);
                    if (we) chk({tag, "_wb_dat_w"}, 32'(wb_dat_w), 32'(dat));
                    if (drop_init) init_done = 1'b0;
                end
                cyc_cnt++;
            end
            seen = rsp_valid;
        end
        chk({tag, "_rsp_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(k), 32'(exp_cyc + 1));
        chk({tag, "_bus_cycles"}, 32'(cyc_cnt), 32'(exp_cyc));
        hold_dat = rsp_dat;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk({tag, "_bp_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_bp_dat"}, 32'(rsp_dat), 32'(hold_dat));
            chk({tag, "_bp_cmd_ready"}, 32'(cmd_ready), 32'd0);
            chk({tag, "_bp_wb_cyc"}, 32'(wb_cyc), 32'd0);
        end
        init_done = 1'b1;
        exp = exp_q.pop_front();
        chk({tag, "_rsp_dat"}, 32'(rsp_dat), 32'(exp[DW-1:0]));
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp[DW]));
        chk({tag, "_rsp_we"}, 32'(rsp_we), 32'(exp[DW+1]));
        chk({tag, "_err_count"}, 32'(err_count), 32'(exp_errs));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : main
        logic [DW-1:0] v;
        int cnt, hold;
        for (int i = 0; i < 4096; i++) begin
            v = DW'($urandom);
            slv_mem[i] = v;
            ref_mem[i] = v;
        end
        slv_mem[12'h123] = 16'hBEEF;
        ref_mem[12'h123] = 16'hBEEF;

        // Reset with init_done already high: the block must still refuse commands.
        init_done = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_wb_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_wb_adr", 32'(wb_adr), 32'd0);
        chk("rst_rsp_dat", 32'(rsp_dat), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        // Read acked on the third bus cycle.
        run_txn(1'b0, 24'h000123, 16'h0000, 2'b11, 2, 0, 0, 1'b0, "rd123");
        // Write then read back the same word.
        run_txn(1'b1, 24'h000010, 16'hA5A5, 2'b11, 0, 0, 0, 1'b0, "wr10");
        run_txn(1'b0, 24'h000010, 16'h0000, 2'b11, 0, 0, 0, 1'b0, "rd10");
        chk("rd10_model", 32'(ref_mem[12'h010]), 32'hA5A5);
        // ack and err together: err wins.
        run_txn(1'b0, 24'h000020, 16'h0000, 2'b11, 1, 2, 0, 1'b0, "ackerr");
        chk("ackerr_count", 32'(err_count), 32'd1);
        // Response backpressure for five cycles, with init_done falling mid-cycle.
        run_txn(1'b0, 24'h000010, 16'h0000, 2'b01, 1, 0, 5, 1'b1, "bp");

        // Stray ack/err while idle must be ignored.
        @(negedge clk);
        stray = 1'b1;
        repeat (2) @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("stray_err_count", 32'(err_count), 32'(exp_errs));

        // init_done low blocks acceptance even with a pending command.
        init_done = 1'b0;
        cmd_valid = 1'b1;
        cmd_adr   = 24'h000055;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (cmd_ready || wb_cyc) cnt++;
        end
        chk("gate_no_accept", 32'(cnt), 32'd0);
        cmd_valid = 1'b0;
        init_done = 1'b1;
        @(negedge clk);
        chk("gate_reopen", 32'(cmd_ready), 32'd1);

        // Randomized traffic over a small address window so reads hit prior writes.
        for (int n = 0; n < 24; n++) begin
            int r, mode;
            r = $urandom_range(0, 9);
            mode = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
            run_txn(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
                    SW'($urandom_range(0, 3)), $urandom_range(0, 3), mode,
                    $urandom_range(0, 2), 1'b0, $sformatf("rnd%0d", n));
        end

`ifdef SDRAM_WB_MASTER_TIMEOUT_EN
        run_txn(1'b0, 24'h000030, 16'h0000, 2'b11, 0, 3, 0, 1'b0, "timeout");
        hold = 3;
`else
        hold = 100;
`endif
        // Silent responder, then reset in the middle of the bus cycle.
        resp_mode = 3;
        send_cmd(1'b0, 24'h000040, 16'h0000, 2'b11, "rstbus");
        cnt = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (wb_cyc) cnt++;
        end
        chk("bus_hold", 32'(cnt), 32'(hold));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midbus_wb_cyc", 32'(wb_cyc), 32'd0);
        chk("midbus_wb_stb", 32'(wb_stb), 32'd0);
        chk("midbus_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midbus_err_count", 32'(err_count), 32'd0);
        chk("midbus_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_errs = '0;
        resp_mode = 0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("post_rst_no_rsp", 32'(cnt), 32'd0);
        run_txn(1'b0, 24'h000123, 16'h0000, 2'b11, 0, 0, 0, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : global_guard
        #400000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "bench did not finish");
    end

endmodule
